// File: rtl/div_f_sched.sv
// div_f_sched: shares one div_f divider between two requesters using round-robin arbitration.
// Operands are held while the divider is busy, and the result is returned on a tagged response channel.
//
// state | meaning
// IDLE  | no operation in flight; the only state that grants a request
// ISSUE | div_sel raised with latched operands; an exception may finish here
// WAIT  | divider busy; operands held; timeout counter running
// RESP  | captured result presented until the consumer takes it
// DRAIN | response delivered but divider still busy; no grants
module div_f_sched #(
    parameter int  RES_W       = 26,
    parameter int  TIMEOUT_CYC = 64,
    localparam int OUT_W       = 11 + RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [OUT_W-1:0] resp_data,
    output logic             resp_dbz,
    output logic             resp_zdiv,
    output logic             resp_timeout,
    output logic             busy,
    output logic             div_sel,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic             div_busy,
    input  logic [OUT_W-1:0] div_out,
    input  logic             div_by_zero,
    input  logic             div_zero_div
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic             rr_ptr;
    logic             id_q;
    logic [31:0]      a_q, b_q;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] data_q;
    logic             dbz_q, zdiv_q, to_q;
    logic             grant_vld, grant_id, accept;
    logic             capture, abort;

    // With both requesters valid, the one that was not served last wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ~rr_ptr : req1_valid;
        accept    = (state == S_IDLE) && grant_vld;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!div_busy) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!div_busy) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_nxt = div_busy ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!div_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= 1'b1;
            id_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            data_q <= '0;
            dbz_q  <= 1'b0;
            zdiv_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= grant_id ? req1_a : req0_a;
                b_q    <= grant_id ? req1_b : req0_b;
                id_q   <= grant_id;
                rr_ptr <= grant_id;
            end
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            // A timed-out operation reports no data and no flags.
            if (capture) begin
                data_q <= div_out;
                dbz_q  <= div_by_zero;
                zdiv_q <= div_zero_div;
                to_q   <= 1'b0;
            end else if (abort) begin
                data_q <= '0;
                dbz_q  <= 1'b0;
                zdiv_q <= 1'b0;
                to_q   <= 1'b1;
            end
        end
    end

    assign div_sel      = (state == S_ISSUE) || (state == S_WAIT);
    assign div_dividend = a_q;
    assign div_divisor  = b_q;
    assign resp_valid   = (state == S_RESP);
    assign resp_id      = id_q;
    assign resp_data    = data_q;
    assign resp_dbz     = dbz_q;
    assign resp_zdiv    = zdiv_q;
    assign resp_timeout = to_q;
    assign busy         = (state != S_IDLE);

endmodule
